// File: rtl/regs_pkg.sv
// Shared definitions for the X/Y/Z register datapath.
// Control codes, ULA selects, commands, FSM states.
package regs_pkg;

  localparam int WIDTH  = 4;
  localparam int CODE_W = 4;

  localparam logic [3:0] CLEAR = 4'd0;
  localparam logic [3:0] HOLD  = 4'd1;
  localparam logic [3:0] LOAD  = 4'd2;
  localparam logic [3:0] SHFTR = 4'd3;
  localparam logic [3:0] SHFTL = 4'd4;

  localparam logic [1:0] ULA_ADD = 2'd0;
  localparam logic [1:0] ULA_SUB = 2'd1;
  localparam logic [1:0] ULA_ACC = 2'd2;

  localparam logic [1:0] CMD_CLR = 2'd0;
  localparam logic [1:0] CMD_ADD = 2'd1;
  localparam logic [1:0] CMD_SUB = 2'd2;
  localparam logic [1:0] CMD_MUL = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_ADD    = 4'd2,
    S_SUB    = 4'd3,
    S_MZ     = 4'd4,
    S_MTEST  = 4'd5,
    S_MADD   = 4'd6,
    S_MSHIFT = 4'd7,
    S_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/unidade_controle.sv
// Control FSM for the X/Y/Z registers and the ULA.
// Moore decode of CLR/ADD/SUB and shift-and-add MUL.
module unidade_controle
  import regs_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic              y_lsb,
  output logic [CODE_W-1:0] Tx,
  output logic [CODE_W-1:0] Ty,
  output logic [CODE_W-1:0] Tz,
  output logic [1:0]        ula_op,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  localparam logic [CODE_W-1:0] C_CLR =
    CODE_W'(CLEAR);
  localparam logic [CODE_W-1:0] C_HOLD =
    CODE_W'(HOLD);
  localparam logic [CODE_W-1:0] C_LOAD =
    CODE_W'(LOAD);
  localparam logic [CODE_W-1:0] C_SHR =
    CODE_W'(SHFTR);
  localparam logic [CODE_W-1:0] C_SHL =
    CODE_W'(SHFTL);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and iteration counter.
  // The command is captured by the IDLE
  // branch target, so the state is cmd_r.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and per-state output decode.
  always_comb begin
    nxt     = S_IDLE;
    cnt_nxt = cnt;
    Tx      = C_HOLD;
    Ty      = C_HOLD;
    Tz      = C_HOLD;
    ula_op  = ULA_ADD;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        nxt  = S_IDLE;
        if (start) begin
          unique case (cmd)
            CMD_CLR: nxt = S_CLR;
            CMD_ADD: nxt = S_ADD;
            CMD_SUB: nxt = S_SUB;
            CMD_MUL: nxt = S_MZ;
          endcase
        end
      end
      S_CLR: begin
        Tx  = C_CLR;
        Ty  = C_CLR;
        Tz  = C_CLR;
        nxt = S_DONE;
      end
      S_ADD: begin
        ula_op = ULA_ADD;
        Tz     = C_LOAD;
        nxt    = S_DONE;
      end
      S_SUB: begin
        ula_op = ULA_SUB;
        Tz     = C_LOAD;
        nxt    = S_DONE;
      end
      S_MZ: begin
        Tz      = C_CLR;
        cnt_nxt = '0;
        nxt     = S_MTEST;
      end
      S_MTEST: begin
        nxt = y_lsb ? S_MADD : S_MSHIFT;
      end
      S_MADD: begin
        ula_op = ULA_ACC;
        Tz     = C_LOAD;
        nxt    = S_MSHIFT;
      end
      S_MSHIFT: begin
        Tx      = C_SHL;
        Ty      = C_SHR;
        cnt_nxt = cnt + 1'b1;
        nxt     = (cnt == LAST) ? S_DONE
                                : S_MTEST;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench: controller plus X/Y/Z register and ULA model.
// Scoreboard of expected Z and done cycle per command.
module tb_unidade_controle;
  import regs_pkg::*;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [1:0] cmd     = 2'd0;
  logic       y_lsb;
  logic [3:0] Tx, Ty, Tz;
  logic [1:0] ula_op;
  logic       busy, done;

  unidade_controle #(.WIDTH(4), .CODE_W(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .cmd    (cmd),
    .y_lsb  (y_lsb),
    .Tx     (Tx),
    .Ty     (Ty),
    .Tz     (Tz),
    .ula_op (ula_op),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  logic [3:0] xr = 4'd0;
  logic [3:0] yr = 4'd0;
  logic [3:0] zr = 4'd0;
  logic [3:0] lx = 4'd0;
  logic [3:0] ly = 4'd0;
  logic       ld = 1'b0;
  logic [3:0] tx_s = HOLD;
  logic [3:0] ty_s = HOLD;
  logic [3:0] tz_s = HOLD;
  logic [1:0] op_s = 2'd0;

  assign y_lsb = yr[0];

  function automatic logic [3:0] ula_f(
    input logic [1:0] op,
    input logic [3:0] x, y, z);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return z + x;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] reg_f(
    input logic [3:0] code,
    input logic [3:0] q, d);
    case (code)
      4'd0:    return 4'd0;
      4'd1:    return q;
      4'd2:    return d;
      4'd3:    return q >> 1;
      4'd4:    return q << 1;
      default: return q;
    endcase
  endfunction

  always @(negedge clock) begin
    tx_s <= Tx;
    ty_s <= Ty;
    tz_s <= Tz;
    op_s <= ula_op;
  end

  always @(posedge clock) begin
    if (ld) begin
      xr <= lx;
      yr <= ly;
    end else begin
      xr <= reg_f(tx_s, xr, xr);
      yr <= reg_f(ty_s, yr, yr);
      zr <= reg_f(tz_s, zr,
              ula_f(op_s, xr, yr, zr));
    end
  end

  typedef struct {
    string      tag;
    logic [3:0] z;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input string      tag,
    input logic [1:0] c,
    input logic [3:0] x, y,
    input int         pulse_at,
    output int        acc);
    exp_t e;
    int   got, shft, nbusy;
    e.tag = tag;
    e.cyc = 2;
    case (c)
      CMD_CLR: e.z = 4'd0;
      CMD_ADD: e.z = x + y;
      CMD_SUB: e.z = x - y;
      default: begin
        e.z = 4'(x * y);
        for (int i = 0; i < 4; i++)
          e.cyc += 2 + int'(y[i]);
      end
    endcase
    sb.push_back(e);
    @(negedge clock);
    lx    = x;
    ly    = y;
    ld    = 1'b1;
    cmd   = c;
    start = 1'b1;
    @(posedge clock);
    #1;
    ld    = 1'b0;
    start = 1'b0;
    cmd   = ~c;
    got   = 0;
    shft  = 0;
    nbusy = 0;
    acc   = 0;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      @(negedge clock);
      if (n == pulse_at) begin
        start = 1'b1;
        cmd   = CMD_ADD;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) nbusy++;
      if (Ty == SHFTR) shft++;
      if (ula_op == ULA_ACC) acc++;
      if (done === 1'b1) got = n;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " done_cycle"}, got, e.cyc);
    chk({e.tag, " z"}, zr, e.z);
    chk({e.tag, " busy_gaps"}, nbusy, 0);
    if (c == CMD_MUL)
      chk({e.tag, " shftr_count"}, shft, 4);
    @(negedge clock);
    chk({e.tag, " idle_busy"}, busy, 1'b0);
    chk({e.tag, " idle_done"}, done, 1'b0);
  endtask

  int acc;

  initial begin
    #12;
    chk("rst Tx", Tx, HOLD);
    chk("rst Ty", Ty, HOLD);
    chk("rst Tz", Tz, HOLD);
    chk("rst ula_op", ula_op, 2'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("mul3x5", CMD_MUL, 4'd3, 4'd5, 0, acc);
    chk("mul3x5 acc_count", acc, 2);

    run_op("mul7x0", CMD_MUL, 4'd7, 4'd0, 0, acc);
    chk("mul7x0 acc_count", acc, 0);

    run_op("add9p8", CMD_ADD, 4'd9, 4'd8, 0, acc);
    run_op("sub2m5", CMD_SUB, 4'd2, 4'd5, 0, acc);

    run_op("clr", CMD_CLR, xr, yr, 0, acc);
    chk("clr x", xr, 4'd0);
    chk("clr y", yr, 4'd0);

    run_op("mul5x3_pulse", CMD_MUL,
           4'd5, 4'd3, 4, acc);

    run_op("mul15x15", CMD_MUL,
           4'd15, 4'd15, 0, acc);

    @(negedge clock);
    lx    = 4'd3;
    ly    = 4'd7;
    ld    = 1'b1;
    cmd   = CMD_MUL;
    start = 1'b1;
    @(posedge clock);
    #1;
    ld    = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("pre_abort busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort Tx", Tx, HOLD);
    chk("abort Ty", Ty, HOLD);
    chk("abort Tz", Tz, HOLD);
    chk("abort ula_op", ula_op, 2'd0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_abort busy", busy, 1'b0);

    run_op("mul2x3", CMD_MUL, 4'd2, 4'd3, 0, acc);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
